// File: rtl/mdio_pkg.sv
// Shared definitions for the clause-22 MDIO master: frame constants, bit indices,
// FSM state type and the latched request record.
package mdio_pkg;

    localparam logic [1:0] MDIO_ST       = 2'b01;
    localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
    localparam logic [1:0] MDIO_OP_READ  = 2'b10;
    localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

    // Bit indices k within the 32-bit frame (after the preamble)
    localparam int K_TA      = 14;
    localparam int K_TA_LAST = 15;
    localparam int K_DATA    = 16;
    localparam int K_LAST    = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_FRAME
    } mdio_state_t;

    typedef enum logic [1:0] {
        PH_HEADER,
        PH_TA,
        PH_DATA
    } mdio_phase_t;

    typedef struct packed {
        logic       write;
        logic [4:0] phy_addr;
        logic [4:0] reg_addr;
        logic [15:0] wdata;
    } mdio_req_t;

    // Read frames fill turnaround/data with ones; those bits are never driven.
    function automatic logic [31:0] build_frame(input mdio_req_t r);
        if (r.write)
            return {MDIO_ST, MDIO_OP_WRITE, r.phy_addr, r.reg_addr, MDIO_TA_WRITE, r.wdata};
        return {MDIO_ST, MDIO_OP_READ, r.phy_addr, r.reg_addr, 18'h3FFFF};
    endfunction

    function automatic mdio_phase_t phase_of(input logic [4:0] k);
        if (k < 5'(K_TA))
            return PH_HEADER;
        if (k < 5'(K_DATA))
            return PH_TA;
        return PH_DATA;
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: half-period counter with strobes flagging the edge on which
// MDC is about to rise or fall, so the master updates on that same clock edge.
module mdio_clk_gen #(
    parameter int HALF_DIV = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic mdc_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = $clog2(HALF_DIV);
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap   = en_i && (cnt == LAST);
    assign rise_o = wrap && !mdc_o;
    assign fall_o = wrap && mdc_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            cnt   <= '0;
            mdc_o <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            mdc_o <= ~mdc_o;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: accepts one register access at a time, serialises the
// frame on MDC/MDIO and returns a single-cycle response with read data and error.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned MDC_FREQ      = 2_500_000,
    parameter int unsigned PREAMBLE_BITS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [4:0]  req_phy_addr_i,
    input  logic [4:0]  req_reg_addr_i,
    input  logic [15:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i
);
    localparam int unsigned HALF_DIV = (CLK_FREQ + 2 * MDC_FREQ - 1) / (2 * MDC_FREQ);
    localparam logic [4:0]  PRE_LAST = 5'(PREAMBLE_BITS - 1);

    if (HALF_DIV < 3) begin : g_bad_div
        $error("mdio_master: HALF_DIV must be at least 3");
    end
    if (PREAMBLE_BITS != 0 && PREAMBLE_BITS != 32) begin : g_bad_pre
        $error("mdio_master: PREAMBLE_BITS must be 0 or 32");
    end

    mdio_state_t state;
    mdio_req_t   req;
    logic [31:0] frame;
    logic [31:0] sh;
    logic [4:0]  idx;
    logic        wr;
    logic [15:0] rd_sh;
    logic        err_sh;
    logic        mdio_meta, mdio_s;
    logic        rise, fall;

    assign req   = '{write: req_write_i, phy_addr: req_phy_addr_i,
                     reg_addr: req_reg_addr_i, wdata: req_wdata_i};
    assign frame = build_frame(req);

    mdio_clk_gen #(.HALF_DIV(int'(HALF_DIV))) u_clk_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (busy_o),
        .mdc_o  (mdc_o),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_ff @(posedge clk_i) begin
        mdio_meta <= mdio_i;
        mdio_s    <= mdio_meta;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            idx         <= '0;
            busy_o      <= 1'b0;
            req_ready_o <= 1'b0;
            mdio_o      <= 1'b1;
            mdio_oe_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        wr          <= req.write;
                        busy_o      <= 1'b1;
                        req_ready_o <= 1'b0;
                        mdio_oe_o   <= 1'b1;
                        idx         <= '0;
                        if (PREAMBLE_BITS == 0) begin
                            state  <= ST_FRAME;
                            mdio_o <= frame[31];
                            sh     <= {frame[30:0], 1'b1};
                        end else begin
                            state  <= ST_PREAMBLE;
                            mdio_o <= 1'b1;
                            sh     <= frame;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (fall) begin
                        if (idx == PRE_LAST) begin
                            state  <= ST_FRAME;
                            idx    <= '0;
                            mdio_o <= sh[31];
                            sh     <= {sh[30:0], 1'b1};
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                ST_FRAME: begin
                    // Reads sample on the edge that raises MDC
                    if (rise && !wr) begin
                        if (idx == 5'(K_TA_LAST))
                            err_sh <= mdio_s;
                        else if (phase_of(idx) == PH_DATA)
                            rd_sh <= {rd_sh[14:0], mdio_s};
                    end
                    if (fall) begin
                        if (idx == 5'(K_LAST)) begin
                            state       <= ST_IDLE;
                            busy_o      <= 1'b0;
                            req_ready_o <= 1'b1;
                            mdio_oe_o   <= 1'b0;
                            mdio_o      <= 1'b1;
                            rsp_valid_o <= 1'b1;
                            rsp_rdata_o <= wr ? 16'h0000 : rd_sh;
                            rsp_err_o   <= wr ? 1'b0 : err_sh;
                        end else begin
                            idx <= idx + 5'd1;
                            sh  <= {sh[30:0], 1'b1};
                            // Read releases the line from the first turnaround bit on
                            if (!wr && phase_of(idx + 5'd1) != PH_HEADER) begin
                                mdio_oe_o <= 1'b0;
                                mdio_o    <= 1'b1;
                            end else begin
                                mdio_o <= sh[31];
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
